// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcodes, flag/tag layouts and arbiter states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_MUL     = 4'd2,
    ALU_DIV     = 4'd3,
    ALU_AND     = 4'd4,
    ALU_OR      = 4'd5,
    ALU_XOR     = 4'd6,
    ALU_NOT     = 4'd7,
    ALU_SHL     = 4'd8,
    ALU_SHR     = 4'd9,
    ALU_INC     = 4'd10,
    ALU_DEC     = 4'd11,
    ALU_ZERO    = 4'd12,
    ALU_ILLEGAL = 4'd13   // first of the undefined opcodes 13..15
  } alu_op_e;

  localparam logic [3:0] OP_ZERO = ALU_ZERO;
  localparam int TAG_ID_W = 3;  // enough for up to 8 requesters

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
  } alu_flags_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                err;
  } alu_tag_t;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic op_is_illegal(input logic [3:0] sel);
    return sel >= ALU_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin grant over N requesters; force_en restricts the search to force_mask.
module alu_rr_arbiter
#(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [N-1:0]     req,
  input  logic             force_en,
  input  logic [N-1:0]     force_mask,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [N-1:0]     eff_req;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    eff_req   = force_en ? (req & force_mask) : req;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N)) begin
        sum = sum - (PTR_W+1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (!grant_any && eff_req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

  // Pointer follows every grant, so a locked owner leaves it at owner+1 on exit.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == PTR_W'(N-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU among NUM_REQ requesters with round-robin/lock arbitration
// and routes each result back to its issuer through a latency-matched tag pipe.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 2,
  parameter int MAX_LOCK    = 8
)
(
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0][3:0]         req_sel,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [WIDTH-1:0]                alu_a,
  output logic [WIDTH-1:0]                alu_b,
  output logic [3:0]                      alu_sel,
  input  logic [WIDTH-1:0]                alu_f,
  input  logic                            alu_z,
  input  logic                            alu_c,
  input  logic                            alu_v,
  input  logic                            alu_n,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [WIDTH-1:0]                rsp_f,
  output logic [3:0]                      rsp_flags,
  output logic                            rsp_err,
  output logic                            locked
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(MAX_LOCK + 1);
  localparam int STAGES = ALU_LATENCY + 1;

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [3:0]         alu_sel_q, alu_sel_d;
  alu_tag_t           tag_q [STAGES];
  alu_tag_t           tag_d [STAGES];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_f_q, rsp_f_d;
  alu_flags_t         rsp_flags_q, rsp_flags_d;
  logic               rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] owner_mask;
  logic [3:0]         gnt_sel;
  logic               gnt_illegal;
  alu_tag_t           last_tag;

  assign owner_mask = NUM_REQ'(1) << owner_q;

  alu_rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .CLK        (CLK),
    .RST        (RST),
    .req        (req_valid),
    .force_en   (state_q == ST_LOCKED),
    .force_mask (owner_mask),
    .grant      (gnt),
    .grant_idx  (gnt_idx),
    .grant_any  (gnt_any)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (gnt_any && req_lock[gnt_idx] && (MAX_LOCK > 1)) begin
          state_d    = ST_LOCKED;
          owner_d    = gnt_idx;
          lock_cnt_d = CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (gnt_any) begin
          if (!req_lock[owner_q] || (lock_cnt_q == CNT_W'(MAX_LOCK - 1))) begin
            state_d    = ST_ARB;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end else if (!req_valid[owner_q]) begin
          state_d    = ST_ARB;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_ARB;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Illegal opcodes go to the ALU as ZERO; the error rides along in the tag.
  always_comb begin
    gnt_sel     = req_sel[gnt_idx];
    gnt_illegal = op_is_illegal(gnt_sel);
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = OP_ZERO;
    if (gnt_any) begin
      alu_a_d   = req_a[gnt_idx];
      alu_b_d   = req_b[gnt_idx];
      alu_sel_d = gnt_illegal ? OP_ZERO : gnt_sel;
    end
    tag_d[0].valid = gnt_any;
    tag_d[0].id    = TAG_ID_W'(gnt_idx);
    tag_d[0].err   = gnt_any & gnt_illegal;
    for (int s = 1; s < STAGES; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // The last tag stage lines up with alu_f; capture on the following edge.
  always_comb begin
    last_tag    = tag_q[STAGES-1];
    rsp_valid_d = '0;
    rsp_f_d     = rsp_f_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    if (last_tag.valid) begin
      rsp_valid_d   = NUM_REQ'(1) << last_tag.id;
      rsp_f_d       = alu_f;
      rsp_flags_d.z = alu_z;
      rsp_flags_d.c = alu_c;
      rsp_flags_d.v = alu_v;
      rsp_flags_d.n = alu_n;
      rsp_err_d     = last_tag.err;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_ARB;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= OP_ZERO;
      for (int s = 0; s < STAGES; s++) begin
        tag_q[s] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_f_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      for (int s = 0; s < STAGES; s++) begin
        tag_q[s] <= tag_d[s];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_f_q     <= rsp_f_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = gnt;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural 2-stage ALU, per-requester op queues,
// and a response scoreboard checked by an independent monitor.
module tb_alu_arbiter;

  logic             CLK;
  logic             RST;
  logic [3:0]       req_valid;
  logic [3:0]       req_lock;
  logic [3:0][11:0] req_a;
  logic [3:0][11:0] req_b;
  logic [3:0][3:0]  req_sel;
  logic [3:0]       req_ready;
  logic [11:0]      alu_a;
  logic [11:0]      alu_b;
  logic [3:0]       alu_sel;
  logic [11:0]      alu_f;
  logic             alu_z, alu_c, alu_v, alu_n;
  logic [3:0]       rsp_valid;
  logic [11:0]      rsp_f;
  logic [3:0]       rsp_flags;
  logic             rsp_err;
  logic             locked;

  alu_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_f     (alu_f),
    .alu_z     (alu_z),
    .alu_c     (alu_c),
    .alu_v     (alu_v),
    .alu_n     (alu_n),
    .rsp_valid (rsp_valid),
    .rsp_f     (rsp_f),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .locked    (locked)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural ALU: result {f, z, c, v, n} two edges after the inputs register.
  function automatic logic [15:0] alu_model(input logic [11:0] a, input logic [11:0] b,
                                            input logic [3:0] s);
    logic [12:0] w;
    logic [23:0] m;
    logic [11:0] f;
    logic        c, v;
    c = 1'b0; v = 1'b0; f = '0; w = '0; m = '0;
    case (s)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; f = w[11:0]; c = w[12];
                  v = (a[11] == b[11]) && (f[11] != a[11]); end
      4'd1: begin f = a - b; c = (a < b); v = (a[11] != b[11]) && (f[11] != a[11]); end
      4'd2: begin m = a * b; f = m[11:0]; c = |m[23:12]; end
      4'd3: begin f = (b == 0) ? 12'hFFF : a / b; c = (b == 0); end
      4'd4: f = a & b;
      4'd5: f = a | b;
      4'd6: f = a ^ b;
      4'd7: f = ~a;
      4'd8: begin f = a << 1; c = a[11]; end
      4'd9: begin f = a >> 1; c = a[0]; end
      4'd10: begin w = {1'b0, a} + 13'd1; f = w[11:0]; c = w[12]; end
      4'd11: begin f = a - 12'd1; c = (a == 0); end
      4'd12: f = '0;
      default: f = 12'hBAD;
    endcase
    return {f, (f == 12'd0), c, v, f[11]};
  endfunction

  logic [15:0] alu_p1, alu_p2;
  always @(posedge CLK) begin
    alu_p1 <= alu_model(alu_a, alu_b, alu_sel);
    alu_p2 <= alu_p1;
  end
  assign {alu_f, alu_z, alu_c, alu_v, alu_n} = alu_p2;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [3:0]  sel;
    logic        lock;
  } op_t;

  typedef struct {
    int          id;
    logic [11:0] f;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  op_t  mem [4][32];
  int   head [4];
  int   tail [4];
  exp_t exp_q [$];
  int   glog [$];
  int   llog [$];
  int   exp_g [$];
  int   exp_l [$];
  int   checks;
  int   errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic load(input int r, input logic [11:0] a, input logic [11:0] b,
                      input logic [3:0] sel, input logic lk);
    mem[r][tail[r]] = '{a: a, b: b, sel: sel, lock: lk};
    tail[r]++;
  endtask

  task automatic expect_rsp(input int id, input logic [11:0] f, input logic [3:0] fl,
                            input logic err);
    exp_t e;
    e.id = id; e.f = f; e.flags = fl; e.err = err;
    exp_q.push_back(e);
  endtask

  function automatic logic ops_pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < 4; i++) if (head[i] != tail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((ops_pending() || exp_q.size() != 0 || locked) && n < 500) begin
      @(posedge CLK);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles required=<500", nm, n);
    end
    repeat (4) @(posedge CLK);
  endtask

  task automatic check_log(input string nm);
    chk($sformatf("%s_grant_count", nm), glog.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < glog.size(); i++) begin
      chk($sformatf("%s_grant%0d_id", nm, i), glog[i], exp_g[i]);
      chk($sformatf("%s_grant%0d_locked", nm, i), llog[i], exp_l[i]);
    end
    glog.delete();
    llog.delete();
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_req_ready"}, req_ready, 4'b0000);
    chk({nm, "_alu_a"}, alu_a, 12'h000);
    chk({nm, "_alu_b"}, alu_b, 12'h000);
    chk({nm, "_alu_sel"}, alu_sel, 4'b1100);
    chk({nm, "_rsp_valid"}, rsp_valid, 4'b0000);
    chk({nm, "_rsp_f"}, rsp_f, 12'h000);
    chk({nm, "_rsp_flags"}, rsp_flags, 4'b0000);
    chk({nm, "_rsp_err"}, rsp_err, 1'b0);
    chk({nm, "_locked"}, locked, 1'b0);
  endtask

  // Requester driver: holds each op until accepted, then presents the next one.
  initial begin
    logic [3:0] acc;
    logic       lk_now;
    req_valid = '0; req_lock = '0; req_a = '0; req_b = '0; req_sel = '0;
    for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
    forever begin
      @(negedge CLK);
      acc    = req_valid & req_ready;
      lk_now = locked;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          head[i]++;
          glog.push_back(i);
          llog.push_back(int'(lk_now));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (head[i] < tail[i]) begin
          req_valid[i] = 1'b1;
          req_lock[i]  = mem[i][head[i]].lock;
          req_a[i]     = mem[i][head[i]].a;
          req_b[i]     = mem[i][head[i]].b;
          req_sel[i]   = mem[i][head[i]].sel;
        end else begin
          req_valid[i] = 1'b0;
          req_lock[i]  = 1'b0;
        end
      end
    end
  end

  // Response monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST && rsp_valid != 4'b0000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected actual=rsp_valid %b f=%h required=no response",
                   rsp_valid, rsp_f);
        end else begin
          e = exp_q.pop_front();
          $display("rsp req_onehot=%b f=%h flags=%b err=%b", rsp_valid, rsp_f, rsp_flags, rsp_err);
          if (rsp_valid !== (4'b0001 << e.id) || rsp_f !== e.f || rsp_flags !== e.flags ||
              rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp_match actual=%b/%h/%b/%b required=%b/%h/%b/%b",
                     rsp_valid, rsp_f, rsp_flags, rsp_err,
                     4'b0001 << e.id, e.f, e.flags, e.err);
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    #1 RST = 1'b0;
    #2 reset_checks("reset");
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // All four at once: strict rotation 0,1,2,3.
    @(negedge CLK);
    load(0, 12'd5, 12'd15, 4'd1, 1'b0);
    load(1, 12'd3, 12'd4, 4'd2, 1'b0);
    load(2, 12'd8, 12'd2, 4'd3, 1'b0);
    load(3, 12'h0F0, 12'h000, 4'd8, 1'b0);
    expect_rsp(0, 12'hFF6, 4'b0101, 1'b0);
    expect_rsp(1, 12'd12, 4'b0000, 1'b0);
    expect_rsp(2, 12'd4, 4'b0000, 1'b0);
    expect_rsp(3, 12'h1E0, 4'b0000, 1'b0);
    exp_g = '{0, 1, 2, 3};
    exp_l = '{0, 0, 0, 0};
    wait_idle("rr_all");
    check_log("rr_all");

    // Single ADD: same-cycle ready and three-edge response latency.
    @(negedge CLK);
    load(0, 12'd15, 12'd1, 4'd0, 1'b0);
    expect_rsp(0, 12'd16, 4'b0000, 1'b0);
    @(posedge CLK);
    #2 chk("add_ready_same_cycle", req_ready, 4'b0001);
    @(posedge CLK);
    #1;
    chk("add_alu_a", alu_a, 12'd15);
    chk("add_alu_sel", alu_sel, 4'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 chk("add_rsp_not_early", rsp_valid, 4'b0000);
    @(posedge CLK);
    #1 chk("add_rsp_at_3_edges", rsp_valid, 4'b0001);
    wait_idle("add");
    exp_g = '{0};
    exp_l = '{0};
    check_log("add");

    // Lock by req2 while req1/req3 wait.
    @(negedge CLK);
    load(2, 12'd15, 12'd0, 4'd10, 1'b1);
    load(2, 12'd15, 12'd0, 4'd10, 1'b1);
    load(2, 12'd15, 12'd0, 4'd10, 1'b0);
    @(negedge CLK);
    load(1, 12'd1, 12'd1, 4'd0, 1'b0);
    load(3, 12'd2, 12'd2, 4'd0, 1'b0);
    expect_rsp(2, 12'd16, 4'b0000, 1'b0);
    expect_rsp(2, 12'd16, 4'b0000, 1'b0);
    expect_rsp(2, 12'd16, 4'b0000, 1'b0);
    expect_rsp(3, 12'd4, 4'b0000, 1'b0);
    expect_rsp(1, 12'd2, 4'b0000, 1'b0);
    exp_g = '{2, 2, 2, 3, 1};
    exp_l = '{0, 1, 1, 0, 0};
    wait_idle("lock3");
    check_log("lock3");

    // req1 holds lock: capped at 8 grants, then req0, then req1 relocks.
    @(negedge CLK);
    for (int i = 0; i < 10; i++) load(1, 12'd1, 12'd1, 4'd0, 1'b1);
    @(negedge CLK);
    load(0, 12'h0FF, 12'd1, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) expect_rsp(1, 12'd2, 4'b0000, 1'b0);
    expect_rsp(0, 12'h100, 4'b0000, 1'b0);
    expect_rsp(1, 12'd2, 4'b0000, 1'b0);
    expect_rsp(1, 12'd2, 4'b0000, 1'b0);
    exp_g = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    exp_l = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    wait_idle("max_lock");
    check_log("max_lock");
    chk("max_lock_released", locked, 1'b0);

    // Illegal opcode 14 goes out as ZERO and returns err.
    @(negedge CLK);
    load(3, 12'd7, 12'd0, 4'd14, 1'b0);
    expect_rsp(3, 12'd0, 4'b1000, 1'b1);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("illegal_alu_a", alu_a, 12'd7);
    chk("illegal_alu_sel", alu_sel, 4'b1100);
    wait_idle("illegal");
    exp_g = '{3};
    exp_l = '{0};
    check_log("illegal");

    // Carry/zero and overflow/negative flag routing.
    @(negedge CLK);
    load(0, 12'hFFF, 12'd1, 4'd0, 1'b0);
    load(0, 12'h7FF, 12'd1, 4'd0, 1'b0);
    expect_rsp(0, 12'h000, 4'b1100, 1'b0);
    expect_rsp(0, 12'h800, 4'b0011, 1'b0);
    exp_g = '{0, 0};
    exp_l = '{0, 0};
    wait_idle("flags");
    check_log("flags");

    // Reset one edge after accepting XOR: in-flight op must never respond.
    @(negedge CLK);
    load(0, 12'h0F0, 12'h00F, 4'd6, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #1 chk("xor_alu_sel", alu_sel, 4'd6);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1 reset_checks("midreset");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(posedge CLK);
    exp_g = '{0};
    exp_l = '{0};
    check_log("midreset");
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one pipelined ALU (WIDTH-bit, SEL opcode, F result plus Z/C/V/N flags) among NUM_REQ requesters. Per-requester valid/ready issue handshake with round-robin arbitration. Optional lock mode gives one requester back-to-back ownership. Tags each issued op through a shift pipe matched to the ALU latency, and routes the result and flags back to the issuing requester as a one-hot response strobe.

Parameters:
WIDTH, 12, operand/result width
NUM_REQ, 4, number of requesters (2..8)
ALU_LATENCY, 2, clock edges from ALU inputs registered to alu_f valid
MAX_LOCK, 8, maximum consecutive grants a locked owner may take

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester op request
req_lock  in  NUM_REQ  request to hold ownership after this op
req_a  in  NUM_REQ x WIDTH  operand A per requester
req_b  in  NUM_REQ x WIDTH  operand B per requester
req_sel  in  NUM_REQ x 4  opcode per requester
req_ready  out  NUM_REQ  grant; at most one bit high
alu_a  out  WIDTH  registered operand A to ALU
alu_b  out  WIDTH  registered operand B to ALU
alu_sel  out  4  registered opcode to ALU
alu_f  in  WIDTH  ALU result
alu_z, alu_c, alu_v, alu_n  in  1 each  ALU flags
rsp_valid  out  NUM_REQ  one-hot response strobe, one cycle
rsp_f  out  WIDTH  result
rsp_flags  out  4  {Z,C,V,N}
rsp_err  out  1  op was illegal (SEL 13..15)
locked  out  1  FSM in LOCKED state

Behaviour:
- Reset (RST low, async): req_ready=0; alu_a=alu_b=0; alu_sel=4'b1100 (ZERO); rsp_valid=0; rsp_f=0; rsp_flags=0; rsp_err=0; tag pipe cleared; rr pointer=0; state=ARB; lock count=0.
- Handshake:
  - Op accepted at the edge where req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid, state and pointer.
  - Requester holds a/b/sel/lock stable while valid and not ready.
  - At most one acceptance per cycle.
- ARB state: round-robin search starting at pointer. After a grant to i, pointer becomes (i+1) mod NUM_REQ. No valid means no grant and no pointer change.
- ARB to LOCKED: on acceptance with req_lock[i]=1. owner=i, lock count=1.
- LOCKED state:
  - Only the owner may be granted; other requesters stall.
  - Each owner acceptance increments lock count.
- LOCKED to ARB, whichever comes first:
  - owner acceptance with req_lock=0;
  - owner acceptance that brings lock count to MAX_LOCK;
  - owner req_valid low for one whole cycle.
  - On exit, pointer becomes owner+1.
- Issue: on acceptance, alu_a/alu_b/alu_sel are registered from the granted requester. With no acceptance, alu_sel=ZERO and operands hold.
- Illegal opcode (SEL 13..15): issued to the ALU as ZERO; the tag carries err=1.
- Tag pipe: {valid, id, err}, ALU_LATENCY+1 stages, shifted every cycle, no stall.
- Response:
  - For an acceptance at edge t, rsp_valid[id] is high for exactly one cycle after edge t+ALU_LATENCY+1, with rsp_f/rsp_flags captured from the ALU outputs.
  - Default latency is 3 edges.
  - Throughput is 1 op/cycle; responses return in issue order.
  - No response backpressure; requesters must sink every response.
- rsp_f, rsp_flags and rsp_err hold their last value when rsp_valid=0.
- Reset mid-operation: all in-flight tags discarded; no rsp_valid for ops accepted before reset.
- Simultaneous valid from all requesters: strict rotation, no starvation in ARB.

Decomposition:
- Shared package alu_pkg holds:
  - opcode enum (ADD=0 .. ZERO=12, illegal range marker);
  - OP_ZERO constant;
  - packed flags struct {z,c,v,n};
  - tag struct {valid, id, err};
  - arbiter state enum {ARB, LOCKED}.
- One sub-module, alu_rr_arbiter: parameterized round-robin grant with pointer update and an optional force-grant mask used for LOCKED.

Test Plan:
- req0 ADD A=15 B=1, others idle -> req_ready[0] in the same cycle; rsp_valid=4'b0001 three edges later; rsp_f=16, flags Z=0 N=0, rsp_err=0.
- All four valid at once with SUB 5-15, MUL 3*4, DIV 8/2, SHL 0x0F0 (reqs 0..3) -> grants 0,1,2,3 on consecutive cycles; responses in the same order: 0xFF6 (N=1), 12, 4, 0x1E0.
- req2 issues three INC 15 with lock=1,1,0 while req1/req3 are valid -> grants 2,2,2 with locked=1; then grants 3,1; all three rsp_f=16 to req2.
- req1 holds lock=1 continuously, req0 valid, MAX_LOCK=8 -> exactly 8 consecutive req1 grants, then req0 granted.
- req3 SEL=4'b1110 A=7 -> alu_sel=4'b1100; rsp_valid[3] with rsp_f=0, Z=1, rsp_err=1.
- Accept XOR 0x0F0^0x00F, pull RST low one edge later -> outputs take reset values immediately; no rsp_valid after RST releases.
